// File: rtl/divider_result_reconstructor_if.sv
// divider_result_reconstructor_if: tuple handshake and result/statistics bundle
interface divider_result_reconstructor_if #(
  parameter int N_W   = 16,
  parameter int D_W   = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N_W-1:0]   n;
  logic [D_W-1:0]   d;
  logic [D_W-1:0]   q;
  logic [D_W-1:0]   r;
  logic             clear_stats;
  logic             busy;
  logic             done;
  logic [N_W-1:0]   n_rec;
  logic [N_W:0]     err;
  logic             exact;
  logic             dz;
  logic [ACC_W-1:0] err_abs_acc;
  logic [CNT_W-1:0] sample_cnt;
  modport master (
    output in_valid, n, d, q, r, clear_stats,
    input  in_ready, busy, done, n_rec, err, exact, dz, err_abs_acc, sample_cnt
  );
  modport slave (
    input  in_valid, n, d, q, r, clear_stats,
    output in_ready, busy, done, n_rec, err, exact, dz, err_abs_acc, sample_cnt
  );
endinterface

// File: rtl/divider_result_reconstructor.sv
// divider_result_reconstructor: rebuilds n from (q, d, r) by shift-add and tracks error statistics
module divider_result_reconstructor #(
  parameter int N_W   = 16,
  parameter int D_W   = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  divider_result_reconstructor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  localparam int S_W = $clog2(D_W);
  state_t           state;
  logic [N_W-1:0]   n_l;
  logic [D_W-1:0]   d_l;
  logic [D_W-1:0]   r_l;
  logic [N_W-1:0]   product;
  logic [N_W-1:0]   mcand;
  logic [D_W-1:0]   mplier;
  logic [S_W-1:0]   step;
  logic [N_W-1:0]   n_sum;
  logic [N_W:0]     diff;
  logic [N_W:0]     diff_abs;
  logic [ACC_W:0]   acc_sum;
  // FIN-cycle datapath: q*d + r never exceeds 16 bits, so n_sum needs no carry
  assign n_sum    = product + N_W'(r_l);
  assign diff     = {1'b0, n_l} - {1'b0, n_sum};
  assign diff_abs = diff[N_W] ? -diff : diff;
  assign acc_sum  = {1'b0, bus.err_abs_acc} + (ACC_W+1)'(diff_abs);
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  // Accept, multiply for D_W edges, then publish results and fold them into the statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      n_l             <= '0;
      d_l             <= '0;
      r_l             <= '0;
      product         <= '0;
      mcand           <= '0;
      mplier          <= '0;
      step            <= '0;
      bus.done        <= 1'b0;
      bus.n_rec       <= '0;
      bus.err         <= '0;
      bus.exact       <= 1'b0;
      bus.dz          <= 1'b0;
      bus.err_abs_acc <= '0;
      bus.sample_cnt  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          n_l     <= bus.n;
          d_l     <= bus.d;
          r_l     <= bus.r;
          product <= '0;
          mcand   <= N_W'(bus.d);
          mplier  <= bus.q;
          step    <= '0;
          state   <= MUL;
        end
        MUL: begin
          product <= mplier[0] ? product + mcand : product;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          step    <= step + 1'b1;
          state   <= (step == S_W'(D_W - 1)) ? FIN : MUL;
        end
        FIN: begin
          bus.n_rec       <= n_sum;
          bus.err         <= diff;
          bus.exact       <= (diff == '0);
          bus.dz          <= (d_l == '0);
          bus.done        <= 1'b1;
          bus.err_abs_acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
          bus.sample_cnt  <= (&bus.sample_cnt) ? bus.sample_cnt : bus.sample_cnt + 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bus.clear_stats) begin
        bus.err_abs_acc <= '0;
        bus.sample_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_divider_result_reconstructor.sv
// tb_divider_result_reconstructor: directed checks of reconstruction, handshake, reset and statistics
module tb_divider_result_reconstructor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   lat;
  int   acc_n;
  int   low_n;
  int   done_n;
  divider_result_reconstructor_if bus ();
  divider_result_reconstructor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic run(input logic [15:0] tn, input logic [7:0] td, input logic [7:0] tq,
                     input logic [7:0] tr, input int clr_at, output int l);
    @(negedge clk);
    bus.n = tn; bus.d = td; bus.q = tq; bus.r = tr; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.n = ~tn; bus.d = ~td; bus.q = ~tq; bus.r = ~tr;
    l = 0;
    while (l < 20) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      bus.clear_stats = (l == clr_at);
      if (bus.done) break;
    end
    bus.clear_stats = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.clear_stats = 1'b0;
    bus.n = '0; bus.d = '0; bus.q = '0; bus.r = '0;
    #1;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_nrec", bus.n_rec, 0);
    chk("rst_cnt", bus.sample_cnt, 0);
    @(negedge clk); rst = 1'b0;
    run(16'd1000, 8'd7, 8'd142, 8'd6, -1, lat);
    chk("ex_lat", lat, 9);
    chk("ex_done", bus.done, 1);
    chk("ex_nrec", bus.n_rec, 1000);
    chk("ex_err", bus.err, 0);
    chk("ex_exact", bus.exact, 1);
    chk("ex_dz", bus.dz, 0);
    chk("ex_cnt", bus.sample_cnt, 1);
    chk("ex_acc", bus.err_abs_acc, 0);
    @(negedge clk);
    chk("done_once", bus.done, 0);
    chk("hold_nrec", bus.n_rec, 1000);
    run(16'd100, 8'd10, 8'd12, 8'd0, -1, lat);
    chk("ap_nrec", bus.n_rec, 120);
    chk("ap_err", bus.err, 32'h1FFEC);
    chk("ap_exact", bus.exact, 0);
    chk("ap_acc", bus.err_abs_acc, 20);
    run(16'd65535, 8'd255, 8'd255, 8'd255, -1, lat);
    chk("hi_nrec", bus.n_rec, 65280);
    chk("hi_err", bus.err, 255);
    chk("hi_acc", bus.err_abs_acc, 275);
    run(16'd0, 8'd255, 8'd255, 8'd255, -1, lat);
    chk("lo_err", bus.err, 32'h10100);
    chk("lo_acc", bus.err_abs_acc, 65555);
    chk("lo_cnt", bus.sample_cnt, 4);
    run(16'd50, 8'd5, 8'd9, 8'd1, 8, lat);
    chk("clr_done", bus.done, 1);
    chk("clr_nrec", bus.n_rec, 46);
    chk("clr_err", bus.err, 4);
    chk("clr_acc", bus.err_abs_acc, 0);
    chk("clr_cnt", bus.sample_cnt, 0);
    acc_n = 0; low_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.n = 16'(3 * i); bus.d = 8'd3; bus.q = 8'(i); bus.r = 8'd1;
      if (bus.in_ready) acc_n++;
      else if (bus.busy) low_n++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hs_accepts", acc_n, 3);
    chk("hs_ready_low", low_n, 27);
    chk("hs_done", bus.done, 1);
    chk("hs_nrec", bus.n_rec, 61);
    chk("hs_err", bus.err, 32'h1FFFF);
    chk("hs_cnt", bus.sample_cnt, 3);
    chk("hs_acc", bus.err_abs_acc, 3);
    @(negedge clk);
    bus.n = 16'd1000; bus.d = 8'd7; bus.q = 8'd142; bus.r = 8'd6; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_ready", bus.in_ready, 1);
    chk("mr_busy", bus.busy, 0);
    chk("mr_nrec", bus.n_rec, 0);
    chk("mr_err", bus.err, 0);
    chk("mr_cnt", bus.sample_cnt, 0);
    chk("mr_acc", bus.err_abs_acc, 0);
    @(negedge clk); rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    chk("mr_nodone", done_n, 0);
    run(16'd1000, 8'd7, 8'd142, 8'd6, -1, lat);
    chk("mr_after_nrec", bus.n_rec, 1000);
    chk("mr_after_cnt", bus.sample_cnt, 1);
    for (int i = 0; i < 300; i++) run(16'd0, 8'd255, 8'd255, 8'd255, -1, lat);
    chk("sat_acc", bus.err_abs_acc, 32'hFFFFFF);
    chk("sat_cnt", bus.sample_cnt, 301);
    run(16'd3, 8'd0, 8'd9, 8'd3, -1, lat);
    chk("dz_nrec", bus.n_rec, 3);
    chk("dz_err", bus.err, 0);
    chk("dz_flag", bus.dz, 1);
    chk("dz_exact", bus.exact, 1);
    chk("dz_acc", bus.err_abs_acc, 32'hFFFFFF);
    chk("dz_cnt", bus.sample_cnt, 302);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
